// File: rtl/block_store.sv
// Brick field store for the game state controller: 30x10 cells of 4-bit block codes,
// combinational cell reads, and multi-cycle LOAD / WIPE / DROP plus single-cycle CLEAR.
module block_store #(
    parameter int ROWS = 30,
    parameter int COLS = 10,
    parameter int CBIT = 9
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            bm_enable,
    input  logic [1:0]      bm_func,
    input  logic [1:0]      bm_stage,
    input  logic [4:0]      bm_row,
    input  logic [4:0]      bm_col,
    output logic [3:0]      bm_block,
    output logic            bm_ready,
    output logic [CBIT-1:0] blocks_left
);
    localparam int CELLS = ROWS * COLS;
    localparam int IW    = $clog2(CELLS);

    localparam logic [IW-1:0] LAST_IDX  = IW'(CELLS - 1);
    localparam logic [IW-1:0] COLS_IDX  = IW'(COLS);
    localparam logic [IW-1:0] FLOOR_IDX = IW'(CELLS - COLS);
    localparam logic [5:0]    ROWS_LIM  = 6'(ROWS);
    localparam logic [5:0]    COLS_LIM  = 6'(COLS);
    localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);

    localparam logic [1:0] F_LOAD  = 2'b00;
    localparam logic [1:0] F_CLEAR = 2'b01;
    localparam logic [1:0] F_WIPE  = 2'b10;
    localparam logic [1:0] F_DROP  = 2'b11;

    localparam logic [3:0] B_EMPTY  = 4'b0000;
    localparam logic [3:0] B_KILLER = 4'b0001;
    localparam logic [3:0] B_NORMAL = 4'b0010;
    localparam logic [3:0] B_HARD   = 4'b0011;
    localparam logic [3:0] B_WIDE   = 4'b0100;
    localparam logic [3:0] B_SOLID  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WIPE,
        S_DROP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cells [CELLS];
    logic [IW-1:0] index;
    logic [4:0]    row_cnt;
    logic [4:0]    col_cnt;
    logic [1:0]    stage_q;
    logic          accept;
    logic          addr_ok;
    logic [IW-1:0] addr;
    logic [3:0]    cur_cell;
    logic [3:0]    pat_code;

    function automatic logic destructible(input logic [3:0] code);
        return (code == B_NORMAL) || (code == B_HARD) || (code == B_WIDE);
    endfunction

    function automatic logic [CBIT-1:0] dec_sat(input logic [CBIT-1:0] n);
        return (n == '0) ? n : n - CBIT'(1);
    endfunction

    function automatic logic [3:0] pattern(input logic [1:0] stage,
                                           input logic [4:0] row,
                                           input logic [4:0] col);
        logic [3:0] code;
        code = B_EMPTY;
        case (stage)
            2'd0: begin
                if (row >= 5'd2 && row <= 5'd7) code = B_NORMAL;
            end
            2'd1: begin
                // Checkerboard: even (row+col) parity is hard
                if (row >= 5'd2 && row <= 5'd9) code = (row[0] ^ col[0]) ? B_NORMAL : B_HARD;
            end
            2'd2: begin
                if (row == 5'd2) code = B_SOLID;
                else if (row >= 5'd4 && row <= 5'd9) code = B_WIDE;
            end
            default: begin
                if (row >= 5'd3 && row <= 5'd10) code = B_NORMAL;
                else if (row == 5'd12) code = col[0] ? B_SOLID : B_KILLER;
            end
        endcase
        return code;
    endfunction

    assign addr_ok  = ({1'b0, bm_row} < ROWS_LIM) && ({1'b0, bm_col} < COLS_LIM);
    assign addr     = IW'(bm_row) * COLS_IDX + IW'(bm_col);
    assign cur_cell = addr_ok ? cells[addr] : B_EMPTY;
    assign bm_ready = (state == S_IDLE);
    assign bm_block = bm_ready ? cur_cell : B_EMPTY;
    assign accept   = bm_ready && bm_enable;
    assign pat_code = pattern(stage_q, row_cnt, col_cnt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bm_func)
                        F_LOAD:  state_nx = S_LOAD;
                        F_WIPE:  state_nx = S_WIPE;
                        F_DROP:  state_nx = S_DROP;
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD, S_WIPE: begin
                if (index == LAST_IDX) state_nx = S_IDLE;
            end
            S_DROP: begin
                if (index == '0) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= B_EMPTY;
            index       <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            stage_q     <= '0;
            blocks_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bm_func)
                            F_LOAD: begin
                                stage_q     <= bm_stage;
                                index       <= '0;
                                row_cnt     <= '0;
                                col_cnt     <= '0;
                                blocks_left <= '0;
                            end
                            F_CLEAR: begin
                                if (cur_cell == B_HARD) begin
                                    cells[addr] <= B_NORMAL;
                                end else if (cur_cell == B_NORMAL || cur_cell == B_WIDE) begin
                                    cells[addr] <= B_EMPTY;
                                    blocks_left <= dec_sat(blocks_left);
                                end
                            end
                            F_WIPE: begin
                                index       <= '0;
                                blocks_left <= '0;
                            end
                            default: begin
                                index <= LAST_IDX;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    cells[index] <= pat_code;
                    if (destructible(pat_code)) blocks_left <= blocks_left + CBIT'(1);
                    index <= index + IW'(1);
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 5'd1;
                    end else begin
                        col_cnt <= col_cnt + 5'd1;
                    end
                end
                S_WIPE: begin
                    cells[index] <= B_EMPTY;
                    index        <= index + IW'(1);
                end
                S_DROP: begin
                    // Walk bottom-up so each source cell is read before it is overwritten
                    if (index >= COLS_IDX) cells[index] <= cells[index - COLS_IDX];
                    else                   cells[index] <= B_EMPTY;
                    if (index >= FLOOR_IDX && destructible(cells[index]))
                        blocks_left <= dec_sat(blocks_left);
                    if (index != '0) index <= index - IW'(1);
                end
                default: begin
                    index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_store.sv
// Self-checking bench for block_store: field-level reference model plus directed and random commands.
module tb_block_store;
    localparam int ROWS  = 30;
    localparam int COLS  = 10;
    localparam int CBIT  = 9;
    localparam int CELLS = ROWS * COLS;

    localparam logic [1:0] F_LOAD  = 2'b00;
    localparam logic [1:0] F_CLEAR = 2'b01;
    localparam logic [1:0] F_WIPE  = 2'b10;
    localparam logic [1:0] F_DROP  = 2'b11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            bm_enable = 1'b0;
    logic [1:0]      bm_func = '0;
    logic [1:0]      bm_stage = '0;
    logic [4:0]      bm_row = '0;
    logic [4:0]      bm_col = '0;
    logic [3:0]      bm_block;
    logic            bm_ready;
    logic [CBIT-1:0] blocks_left;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: the whole field after each command, and the cycles it stays busy
    logic [3:0] m [ROWS][COLS];
    int busy = 0;

    block_store #(.ROWS(ROWS), .COLS(COLS), .CBIT(CBIT)) dut (
        .clock(clock),
        .reset(reset),
        .bm_enable(bm_enable),
        .bm_func(bm_func),
        .bm_stage(bm_stage),
        .bm_row(bm_row),
        .bm_col(bm_col),
        .bm_block(bm_block),
        .bm_ready(bm_ready),
        .blocks_left(blocks_left)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_pattern(input int s, input int r, input int c);
        case (s)
            0: return (r >= 2 && r <= 7) ? 4'b0010 : 4'b0000;
            1: begin
                if (r >= 2 && r <= 9) return ((r + c) % 2 == 0) ? 4'b0011 : 4'b0010;
                return 4'b0000;
            end
            2: begin
                if (r == 2) return 4'b0111;
                if (r >= 4 && r <= 9) return 4'b0100;
                return 4'b0000;
            end
            default: begin
                if (r >= 3 && r <= 10) return 4'b0010;
                if (r == 12) return (c % 2 == 0) ? 4'b0001 : 4'b0111;
                return 4'b0000;
            end
        endcase
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m[r][c] == 4'b0010 || m[r][c] == 4'b0011 || m[r][c] == 4'b0100) n++;
        return n;
    endfunction

    function automatic int model_read(input int r, input int c);
        if (r < ROWS && c < COLS) return int'(m[r][c]);
        return 0;
    endfunction

    task automatic model_cmd(input logic [1:0] f, input int s, input int r, input int c);
        case (f)
            F_LOAD: begin
                for (int rr = 0; rr < ROWS; rr++)
                    for (int cc = 0; cc < COLS; cc++) m[rr][cc] = ref_pattern(s, rr, cc);
                busy = CELLS;
            end
            F_CLEAR: begin
                if (r < ROWS && c < COLS) begin
                    if (m[r][c] == 4'b0011) m[r][c] = 4'b0010;
                    else if (m[r][c] == 4'b0010 || m[r][c] == 4'b0100) m[r][c] = 4'b0000;
                end
            end
            F_WIPE: begin
                for (int rr = 0; rr < ROWS; rr++)
                    for (int cc = 0; cc < COLS; cc++) m[rr][cc] = 4'b0000;
                busy = CELLS;
            end
            default: begin
                for (int rr = ROWS - 1; rr > 0; rr--)
                    for (int cc = 0; cc < COLS; cc++) m[rr][cc] = m[rr-1][cc];
                for (int cc = 0; cc < COLS; cc++) m[0][cc] = 4'b0000;
                busy = CELLS;
            end
        endcase
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int rr = 0; rr < ROWS; rr++)
                for (int cc = 0; cc < COLS; cc++) m[rr][cc] = 4'b0000;
            busy = 0;
        end else if (busy > 0) begin
            busy--;
        end else if (bm_enable) begin
            model_cmd(bm_func, int'(bm_stage), int'(bm_row), int'(bm_col));
        end
    end

    always @(negedge clock) begin
        if (reset && chk_en) begin
            check("ready", int'(bm_ready), int'(busy == 0));
            if (busy == 0) begin
                check("blocks_left", int'(blocks_left), model_count());
                check("bm_block", int'(bm_block), model_read(int'(bm_row), int'(bm_col)));
            end else begin
                check("busy_block", int'(bm_block), 0);
            end
        end
    end

    task automatic read_cell(input int r, input int c, output int v);
        @(posedge clock);
        #1;
        bm_row = 5'(r);
        bm_col = 5'(c);
        @(negedge clock);
        v = int'(bm_block);
    endtask

    task automatic issue(input logic [1:0] f, input int s, input int r, input int c);
        @(posedge clock);
        #1;
        bm_enable = 1'b1;
        bm_func   = f;
        bm_stage  = 2'(s);
        bm_row    = 5'(r);
        bm_col    = 5'(c);
        @(posedge clock);
        #1;
        bm_enable = 1'b0;
    endtask

    task automatic wait_idle(output int lo);
        lo = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (bm_ready) break;
            lo++;
        end
        check("ready_timeout", int'(bm_ready), 1);
    endtask

    task automatic command(input logic [1:0] f, input int s, input int r, input int c, output int lo);
        issue(f, s, r, c);
        if (f == F_CLEAR) lo = 0;
        else wait_idle(lo);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        int v;
        int sel;
        logic [1:0] f;

        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_ready", int'(bm_ready), 1);
        check("reset_count", int'(blocks_left), 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                check("reset_cell", v, 0);
            end

        command(F_LOAD, 0, 0, 0, lo);
        check("load0_busy_cycles", lo, 300);
        read_cell(2, 0, v);  check("load0_r2c0", v, 2);
        read_cell(8, 0, v);  check("load0_r8c0", v, 0);
        check("load0_count", int'(blocks_left), 60);

        command(F_LOAD, 1, 0, 0, lo);
        command(F_CLEAR, 0, 2, 0, lo);
        read_cell(2, 0, v);  check("hard_hit_once", v, 2);
        check("hard_hit_count", int'(blocks_left), 80);
        command(F_CLEAR, 0, 2, 0, lo);
        read_cell(2, 0, v);  check("hard_hit_twice", v, 0);
        check("hard_twice_count", int'(blocks_left), 79);
        command(F_CLEAR, 0, 2, 1, lo);
        read_cell(2, 1, v);  check("normal_hit", v, 0);
        check("normal_hit_count", int'(blocks_left), 78);

        command(F_LOAD, 3, 0, 0, lo);
        command(F_CLEAR, 0, 12, 0, lo);
        command(F_CLEAR, 0, 12, 1, lo);
        command(F_CLEAR, 0, 0, 15, lo);
        read_cell(12, 0, v); check("killer_kept", v, 1);
        read_cell(12, 1, v); check("solid_kept", v, 7);
        read_cell(0, 15, v); check("oob_read", v, 0);
        check("stage3_count", int'(blocks_left), 80);

        command(F_LOAD, 0, 0, 0, lo);
        command(F_DROP, 0, 0, 0, lo);
        check("drop_busy_cycles", lo, 300);
        read_cell(2, 0, v);  check("drop_r2", v, 0);
        read_cell(3, 0, v);  check("drop_r3", v, 2);
        read_cell(8, 9, v);  check("drop_r8", v, 2);
        check("drop_count", int'(blocks_left), 60);
        for (int i = 0; i < 22; i++) command(F_DROP, 0, 0, 0, lo);
        read_cell(25, 0, v); check("drop23_r25", v, 2);
        read_cell(29, 9, v); check("drop23_r29", v, 2);
        read_cell(24, 5, v); check("drop23_r24", v, 0);
        check("drop23_count", int'(blocks_left), 50);

        // WIPE strobe in the middle of a LOAD must be ignored
        issue(F_LOAD, 2, 0, 0);
        repeat (150) @(posedge clock);
        #1;
        bm_enable = 1'b1;
        bm_func   = F_WIPE;
        @(posedge clock);
        #1;
        bm_enable = 1'b0;
        wait_idle(lo);
        check("midload_rest_cycles", lo, 149);
        check("midload_count", int'(blocks_left), 60);
        read_cell(2, 0, v);  check("midload_r2", v, 7);
        read_cell(4, 5, v);  check("midload_r4", v, 4);

        // Reset pulse in the middle of a LOAD
        issue(F_LOAD, 1, 2, 0);
        repeat (150) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_reset_ready", int'(bm_ready), 1);
        check("async_reset_count", int'(blocks_left), 0);
        check("async_reset_cell", int'(bm_block), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                check("post_reset_cell", v, 0);
            end

        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 1)      f = F_LOAD;
            else if (sel <= 6) f = F_CLEAR;
            else if (sel == 7) f = F_WIPE;
            else               f = F_DROP;
            command(f, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 13)),
                    int'($urandom_range(0, 15)), lo);
            if (f != F_CLEAR) check("rand_busy_cycles", lo, 300);
            repeat (int'($urandom_range(1, 4)))
                read_cell(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), v);
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
